// File: rtl/chroma_key_pipe.sv
// chroma_key_pipe: four-stage pipelined chroma-key stage with frame-latched
// configuration, mask/replace output modes and a per-frame keyed-pixel count.
module chroma_key_pipe #(
  parameter int                DW         = 8,
  parameter int                CNT_W      = 20,
  parameter logic [3*DW-1:0]   THRESH_RST = (3*DW)'(82906)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [DW-1:0]     in_r,
  input  logic [DW-1:0]     in_g,
  input  logic [DW-1:0]     in_b,
  input  logic [1:0]        cfg_key_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [3*DW-1:0]   cfg_thresh,
  input  logic [DW-1:0]     cfg_repl_r,
  input  logic [DW-1:0]     cfg_repl_g,
  input  logic [DW-1:0]     cfg_repl_b,
  output logic              out_valid,
  output logic              out_sof,
  output logic              out_eof,
  output logic [DW-1:0]     out_r,
  output logic [DW-1:0]     out_g,
  output logic [DW-1:0]     out_b,
  output logic              out_key,
  output logic [CNT_W-1:0]  frame_key_count,
  output logic              count_valid
);

  // Everything a pixel needs besides its score travels with it in one bundle,
  // so a config change can never split one pixel's evaluation.
  typedef struct packed {
    logic            sof;
    logic            eof;
    logic [DW-1:0]   r;
    logic [DW-1:0]   g;
    logic [DW-1:0]   b;
    logic [1:0]      mode;
    logic [3*DW-1:0] thresh;
    logic [DW-1:0]   repl_r;
    logic [DW-1:0]   repl_g;
    logic [DW-1:0]   repl_b;
  } side_t;

  logic              cap;
  logic [1:0]        key_ch_d, key_ch_q;
  logic [1:0]        mode_d, mode_q;
  logic [3*DW-1:0]   thresh_d, thresh_q;
  logic [DW-1:0]     repl_r_d, repl_r_q, repl_g_d, repl_g_q, repl_b_d, repl_b_q;

  side_t             side0_d, side0_q, side1_q, side2_q, side3_q;
  logic [1:0]        kch0_q;
  logic              v0_q, v1_q, v2_q, v3_q;

  logic [DW-1:0]     k_s1, a_s1, b_s1;
  logic [DW:0]       d1_d, d2_d, d1_q, d2_q;
  logic              pos_d, pos1_q, pos2_q;
  logic [DW-1:0]     k1_q, d2lo2_q;
  logic [2*DW-1:0]   p1_d, p1_q;
  logic [3*DW-1:0]   score_d, score_q;

  logic              key_d;
  logic [DW-1:0]     pix_r_d, pix_g_d, pix_b_d;
  logic [CNT_W-1:0]  run_d, run_q, base_cnt, inc_cnt, fkc_d;
  logic              cv_d;

  assign cap = in_valid && in_sof;

  // A valid sof pixel uses the live config; every other pixel uses the shadow copy.
  always_comb begin
    key_ch_d = cap ? cfg_key_ch : key_ch_q;
    mode_d   = cap ? cfg_mode   : mode_q;
    thresh_d = cap ? cfg_thresh : thresh_q;
    repl_r_d = cap ? cfg_repl_r : repl_r_q;
    repl_g_d = cap ? cfg_repl_g : repl_g_q;
    repl_b_d = cap ? cfg_repl_b : repl_b_q;
  end

  // Shadow config registers, latched on a valid start-of-frame pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_ch_q <= 2'd1;
      mode_q   <= 2'd0;
      thresh_q <= THRESH_RST;
      repl_r_q <= '0;
      repl_g_q <= '0;
      repl_b_q <= '0;
    end else begin
      key_ch_q <= key_ch_d;
      mode_q   <= mode_d;
      thresh_q <= thresh_d;
      repl_r_q <= repl_r_d;
      repl_g_q <= repl_g_d;
      repl_b_q <= repl_b_d;
    end
  end

  // Bundle the incoming pixel with its framing (ignored on bubbles) and config.
  always_comb begin
    side0_d.sof    = in_valid && in_sof;
    side0_d.eof    = in_valid && in_eof;
    side0_d.r      = in_r;
    side0_d.g      = in_g;
    side0_d.b      = in_b;
    side0_d.mode   = mode_d;
    side0_d.thresh = thresh_d;
    side0_d.repl_r = repl_r_d;
    side0_d.repl_g = repl_g_d;
    side0_d.repl_b = repl_b_d;
  end

  // Pick the key channel and the two remaining channels in R,G,B order.
  always_comb begin
    k_s1 = side0_q.g;
    a_s1 = side0_q.r;
    b_s1 = side0_q.b;
    case (kch0_q)
      2'd0: begin
        k_s1 = side0_q.r;
        a_s1 = side0_q.g;
        b_s1 = side0_q.b;
      end
      2'd2: begin
        k_s1 = side0_q.b;
        a_s1 = side0_q.r;
        b_s1 = side0_q.g;
      end
      default: ;
    endcase
    d1_d  = {1'b0, k_s1} - {1'b0, a_s1};
    d2_d  = {1'b0, k_s1} - {1'b0, b_s1};
    pos_d = !d1_d[DW] && (d1_d != '0) && !d2_d[DW] && (d2_d != '0);
  end

  // Partial and full products; widths are chosen so neither product can wrap.
  always_comb begin
    p1_d    = {{DW{1'b0}}, k1_q} * {{DW{1'b0}}, d1_q[DW-1:0]};
    score_d = pos2_q ? ({{DW{1'b0}}, p1_q} * {{(2*DW){1'b0}}, d2lo2_q}) : '0;
  end

  // Pipeline valid bits; in-flight pixels are dropped on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v0_q <= in_valid;
      v1_q <= v0_q;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // Pipeline data registers; contents only matter while the matching valid is set.
  always_ff @(posedge clk) begin
    side0_q <= side0_d;
    kch0_q  <= key_ch_d;
    side1_q <= side0_q;
    k1_q    <= k_s1;
    d1_q    <= d1_d;
    d2_q    <= d2_d;
    pos1_q  <= pos_d;
    side2_q <= side1_q;
    p1_q    <= p1_d;
    d2lo2_q <= d2_q[DW-1:0];
    pos2_q  <= pos1_q;
    side3_q <= side2_q;
    score_q <= score_d;
  end

  // Keying decision, output pixel selection and the running keyed-pixel count.
  always_comb begin
    key_d   = v3_q && (score_q > side3_q.thresh) &&
              ((side3_q.mode == 2'd1) || (side3_q.mode == 2'd2));
    pix_r_d = out_r;
    pix_g_d = out_g;
    pix_b_d = out_b;
    if (v3_q) begin
      case (side3_q.mode)
        2'd1: begin
          pix_r_d = key_d ? side3_q.repl_r : side3_q.r;
          pix_g_d = key_d ? side3_q.repl_g : side3_q.g;
          pix_b_d = key_d ? side3_q.repl_b : side3_q.b;
        end
        2'd2: begin
          pix_r_d = {DW{key_d}};
          pix_g_d = {DW{key_d}};
          pix_b_d = {DW{key_d}};
        end
        default: begin
          pix_r_d = side3_q.r;
          pix_g_d = side3_q.g;
          pix_b_d = side3_q.b;
        end
      endcase
    end
    base_cnt = side3_q.sof ? '0 : run_q;
    inc_cnt  = (key_d && (base_cnt != '1)) ? base_cnt + 1'b1 : base_cnt;
    run_d    = run_q;
    fkc_d    = frame_key_count;
    cv_d     = 1'b0;
    if (v3_q) begin
      if (side3_q.eof) begin
        fkc_d = inc_cnt;
        cv_d  = 1'b1;
        run_d = '0;
      end else begin
        run_d = inc_cnt;
      end
    end
  end

  // Output registers and frame statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_sof         <= 1'b0;
      out_eof         <= 1'b0;
      out_key         <= 1'b0;
      out_r           <= '0;
      out_g           <= '0;
      out_b           <= '0;
      frame_key_count <= '0;
      count_valid     <= 1'b0;
      run_q           <= '0;
    end else begin
      out_valid       <= v3_q;
      out_sof         <= v3_q && side3_q.sof;
      out_eof         <= v3_q && side3_q.eof;
      out_key         <= key_d;
      out_r           <= pix_r_d;
      out_g           <= pix_g_d;
      out_b           <= pix_b_d;
      frame_key_count <= fkc_d;
      count_valid     <= cv_d;
      run_q           <= run_d;
    end
  end

endmodule

// File: tb/tb_chroma_key_pipe.sv
// tb_chroma_key_pipe: directed and randomized checks of chroma_key_pipe against
// a frame-level reference model with a fixed four-cycle delay line.
module tb_chroma_key_pipe;

  localparam int DW         = 8;
  localparam int CNT_W      = 20;
  localparam int THRESH_RST = 82906;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid, in_sof, in_eof;
  logic [DW-1:0]     in_r, in_g, in_b;
  logic [1:0]        cfg_key_ch, cfg_mode;
  logic [3*DW-1:0]   cfg_thresh;
  logic [DW-1:0]     cfg_repl_r, cfg_repl_g, cfg_repl_b;
  logic              out_valid, out_sof, out_eof, out_key, count_valid;
  logic [DW-1:0]     out_r, out_g, out_b;
  logic [CNT_W-1:0]  frame_key_count;

  chroma_key_pipe #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .cfg_key_ch(cfg_key_ch), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .cfg_repl_r(cfg_repl_r), .cfg_repl_g(cfg_repl_g), .cfg_repl_b(cfg_repl_b),
    .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_key(out_key),
    .frame_key_count(frame_key_count), .count_valid(count_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    bit sof;
    bit eof;
    bit key;
    int r;
    int g;
    int b;
  } rec_t;

  rec_t pipeQ[4];
  int compared = 0;
  int mismatched = 0;

  int cfgKch, cfgMode, cfgThresh, cfgRr, cfgRg, cfgRb;
  int shKch, shMode, shThresh, shRr, shRg, shRb;
  int runCnt;
  bit eValid, eSof, eEof, eKey, eCv;
  int eR, eG, eB, eFkc;

  function automatic int modelScore(input int r, input int g, input int b, input int kch);
    int k, a, c;
    if (kch == 0) begin k = r; a = g; c = b; end
    else if (kch == 2) begin k = b; a = r; c = g; end
    else begin k = g; a = r; c = b; end
    if (k > a && k > c) return k * (k - a) * (k - c);
    return 0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) pipeQ[i] = '{default: 0};
    shKch = 1; shMode = 0; shThresh = THRESH_RST; shRr = 0; shRg = 0; shRb = 0;
    runCnt = 0;
    eValid = 0; eSof = 0; eEof = 0; eKey = 0; eCv = 0;
    eR = 0; eG = 0; eB = 0; eFkc = 0;
  endtask

  task automatic modelEdge(input bit v, input bit sof, input bit eof,
                           input int r, input int g, input int b);
    rec_t nr, o;
    int score, base, nxt;
    nr = '{default: 0};
    if (v) begin
      if (sof) begin
        shKch = cfgKch; shMode = cfgMode; shThresh = cfgThresh;
        shRr = cfgRr; shRg = cfgRg; shRb = cfgRb;
      end
      score = modelScore(r, g, b, shKch);
      nr.valid = 1; nr.sof = sof; nr.eof = eof;
      nr.key = (score > shThresh) && (shMode == 1 || shMode == 2);
      nr.r = r; nr.g = g; nr.b = b;
      if (shMode == 1 && nr.key) begin nr.r = shRr; nr.g = shRg; nr.b = shRb; end
      if (shMode == 2) begin
        nr.r = nr.key ? 255 : 0; nr.g = nr.r; nr.b = nr.r;
      end
    end
    o = pipeQ[3];
    pipeQ[3] = pipeQ[2];
    pipeQ[2] = pipeQ[1];
    pipeQ[1] = pipeQ[0];
    pipeQ[0] = nr;
    eValid = o.valid; eSof = o.sof; eEof = o.eof; eKey = o.key; eCv = 0;
    if (o.valid) begin
      eR = o.r; eG = o.g; eB = o.b;
      base = o.sof ? 0 : runCnt;
      nxt = base + (o.key ? 1 : 0);
      if (nxt > CNT_MAX) nxt = CNT_MAX;
      if (o.eof) begin eFkc = nxt; eCv = 1; runCnt = 0; end
      else runCnt = nxt;
    end
  endtask

  task automatic checkOne(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkOne("out_valid", 32'(out_valid), 32'(eValid));
    checkOne("out_sof", 32'(out_sof), 32'(eSof));
    checkOne("out_eof", 32'(out_eof), 32'(eEof));
    checkOne("out_key", 32'(out_key), 32'(eKey));
    checkOne("out_r", 32'(out_r), eR);
    checkOne("out_g", 32'(out_g), eG);
    checkOne("out_b", 32'(out_b), eB);
    checkOne("frame_key_count", 32'(frame_key_count), eFkc);
    checkOne("count_valid", 32'(count_valid), 32'(eCv));
  endtask

  task automatic applyStimulus(input bit rstn, input bit v, input bit sof, input bit eof,
                               input int r, input int g, input int b);
    @(negedge clk);
    rst_n = rstn; in_valid = v; in_sof = sof; in_eof = eof;
    in_r = DW'(r); in_g = DW'(g); in_b = DW'(b);
    cfg_key_ch = 2'(cfgKch); cfg_mode = 2'(cfgMode); cfg_thresh = (3*DW)'(cfgThresh);
    cfg_repl_r = DW'(cfgRr); cfg_repl_g = DW'(cfgRg); cfg_repl_b = DW'(cfgRb);
    @(posedge clk);
    if (!rstn) modelReset();
    else modelEdge(v, sof, eof, r, g, b);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Counter frame: ten valid pixels, three of them keyed, with bubbles between.
  int cv[14] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1};
  int cr[14] = '{20, 100, 0, 10, 0, 0, 100, 50, 0, 30, 1, 40, 0, 5};
  int cg[14] = '{200, 120, 0, 50, 255, 0, 120, 60, 0, 31, 2, 180, 0, 5};
  int cb[14] = '{30, 100, 0, 60, 0, 0, 100, 70, 0, 29, 3, 40, 0, 5};

  initial begin
    bit inFrame, v, sof, eof;
    cfgKch = 1; cfgMode = 0; cfgThresh = THRESH_RST; cfgRr = 0; cfgRg = 0; cfgRb = 0;
    modelReset();
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    in_r = '0; in_g = '0; in_b = '0;

    applyStimulus(0, 1, 1, 1, 1, 2, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Bypass after reset, key G.
    applyStimulus(1, 1, 1, 1, 20, 200, 30);
    idle(5);

    // Replace mode with blue replacement colour; mode changes mid-frame are ignored.
    cfgMode = 1; cfgRr = 0; cfgRg = 0; cfgRb = 255;
    applyStimulus(1, 1, 1, 0, 20, 200, 30);
    applyStimulus(1, 1, 0, 0, 100, 120, 100);
    applyStimulus(1, 1, 0, 0, 10, 50, 60);
    applyStimulus(1, 1, 0, 0, 0, 255, 0);
    cfgMode = 0;
    applyStimulus(1, 1, 0, 0, 20, 200, 30);
    applyStimulus(1, 0, 1, 1, 9, 9, 9);
    applyStimulus(1, 1, 0, 1, 20, 200, 30);
    applyStimulus(1, 1, 1, 1, 20, 200, 30);
    idle(5);

    // Mask view with key B.
    cfgKch = 2; cfgMode = 2;
    applyStimulus(1, 1, 1, 0, 10, 20, 250);
    applyStimulus(1, 1, 0, 1, 250, 20, 10);
    idle(5);

    // Keyed-pixel counter across a frame with bubbles, then a one-pixel frame.
    cfgKch = 1; cfgMode = 1;
    for (int i = 0; i < 14; i++)
      applyStimulus(1, cv[i] != 0, i == 0, i == 13, cr[i], cg[i], cb[i]);
    applyStimulus(1, 1, 1, 1, 20, 200, 30);
    idle(5);

    // Reset with three pixels in flight.
    applyStimulus(1, 1, 1, 0, 20, 200, 30);
    applyStimulus(1, 1, 0, 0, 0, 255, 0);
    applyStimulus(1, 1, 0, 1, 40, 180, 40);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    idle(6);

    // Randomized traffic with random config on every cycle.
    inFrame = 0;
    for (int i = 0; i < 600; i++) begin
      cfgKch = $urandom_range(0, 3);
      cfgMode = $urandom_range(0, 3);
      cfgThresh = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 200000)
                                             : $urandom_range(0, 16777215);
      cfgRr = $urandom_range(0, 255); cfgRg = $urandom_range(0, 255); cfgRb = $urandom_range(0, 255);
      v = $urandom_range(0, 3) != 0;
      sof = !inFrame || ($urandom_range(0, 15) == 0);
      eof = $urandom_range(0, 7) == 0;
      if (!v) begin
        sof = $urandom_range(0, 1) == 1;
        eof = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 149) == 0) begin
        applyStimulus(0, v, sof, eof, 0, 0, 0);
        inFrame = 0;
      end else begin
        applyStimulus(1, v, sof, eof, $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255));
        if (v && sof) inFrame = 1;
        if (v && eof) inFrame = 0;
      end
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
